lsu_issue_queue: RTL and testbench
==================================

Name: lsu_issue_queue

Overview:
Memory reservation station directly upstream of the load/store unit. Holds dispatched loads and stores until their source operands are available, capturing operands from decode and from the result broadcast bus. Selects the oldest ready entry each cycle and drives the LSU execute inputs: address operands, store data, funct3, ROB index and LQ/SQ slot. Supports mispredict flush by ROB mask.

Parameters:
DEPTH, 4, number of queue entries (power of two, 2..8)
TAG_W, 7, physical register tag width
ROB_W, 3, ROB index width (flush_mask is 2**ROB_W bits)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
decode_valid  in  1  dispatch slot valid
DC_fu_sel  in  3  6=load, 7=store; other values ignored
DC_rob_idx  in  ROB_W  ROB index of dispatched op
DC_lsq_idx  in  3  LQ_tail (load) or SQ_tail (store) sampled at dispatch
DC_funct3  in  3  memory funct3
DC_imm  in  32  immediate
DC_rs1_tag / DC_rs2_tag  in  TAG_W  source tags
DC_rs1_rdy / DC_rs2_rdy  in  1  operand already available
DC_rs1_data / DC_rs2_data  in  32  operand value when ready
iq_ready  out  1  queue not full
cdb_valid  in  2  result broadcast valid (port0 ALU, port1 LSU load)
cdb_tag  in  2xTAG_W  broadcast tags
cdb_data  in  2x32  broadcast values
lsu_busy  in  1  LSU cannot accept an issue this cycle (store committing to DM)
ld_i_valid / st_i_valid  out  1  registered issue strobe, load / store
lsu_i_rs1_data / lsu_i_rs2_data / lsu_i_imm  out  32  issued operands
funct3  out  3  issued funct3
lsu_i_rob_idx  out  ROB_W  issued ROB index
EX_ld_idx / EX_st_idx  out  3  issued LQ / SQ slot (only the one matching the strobe is meaningful)
mispredict  in  1  flush request
flush_mask  in  2**ROB_W  ROB entries to kill

Behaviour:
- Reset (async, rst_n=0): all entries invalid, age state cleared, ld_i_valid=st_i_valid=0, all data outputs 0, iq_ready=1.
- Entry fields: valid, is_st, rob_idx, lsq_idx, f3, imm, rs1/rs2 tag, rdy, data.
- Dispatch: accepted when decode_valid && fu_sel∈{6,7} && iq_ready && !mispredict. Writes the lowest-index free entry. Load entries mark rs2 ready regardless of DC_rs2_rdy. The entry is visible to select the next cycle.
- iq_ready = any entry free. It is computed from current state only; an issue in the same cycle does not free a slot for the same-cycle dispatch.
- Wakeup: for each valid entry and each operand not ready, a cdb_valid[p] with matching tag sets rdy and captures data. Port 0 takes priority if both match. The woken operand becomes selectable the next cycle.
- Select: an entry is eligible when valid, rs1 ready, and rs2 ready (stores only). Pick the oldest eligible entry via a DEPTH×DEPTH age matrix: on dispatch, the new row is set to all other valid entries; clear the column on free. Select is inhibited while lsu_busy=1.
- Issue: the selected entry is freed at the clock edge. Outputs are registered: selection in cycle N gives strobe plus fields in cycle N+1 for exactly one cycle. Minimum dispatch-to-strobe is 2 cycles with operands ready.
- Mispredict: entries with flush_mask[rob_idx]=1 are invalidated, and no dispatch occurs that cycle. If the op being selected that cycle is flushed, the next-cycle strobe is 0. A strobe already in the output register is not retracted. The LSU discards it by its own flush.
- Strobes are mutually exclusive. Data outputs hold their last value when the strobe is 0.
- Full with no issue: dispatch is dropped and upstream must stall on iq_ready. Empty: no strobe.

Optional Feature:
LSIQ_DISPATCH_BYPASS_EN
- Defined: at dispatch, an operand with rdy=0 whose tag matches a same-cycle cdb_valid broadcast is written as ready with cdb_data.
- Undefined: that operand stays waiting. This case deadlocks unless the producer re-broadcasts, so upstream rename must guarantee rdy already reflects same-cycle broadcasts.

Decomposition:
- Shared package lsu_pkg: the lsiq_entry_t struct, FU_LD=6 and FU_ST=7 constants, and the funct3 load/store encodings.
- One sub-module, lsiq_age_select: age matrix plus oldest-eligible one-hot/index picker, parameterized by DEPTH.

Test Plan:
- Load dispatched with rs1 ready (data 0x100, imm 4, lsq_idx 2) -> ld_i_valid=1 two cycles later, rs1=0x100, imm=4, EX_ld_idx=2.
- Store waiting on rs2 tag 0x15 -> no strobe. Broadcast cdb port1 tag 0x15 data 0xDEADBEEF -> st_i_valid one cycle after the following select, rs2_data=0xDEADBEEF.
- Four loads fill the queue -> iq_ready=0 and a fifth dispatch is dropped. Make all ready -> issue in dispatch order, one per cycle.
- Older store not ready, younger load ready -> load issues first. Then the store issues after wakeup.
- Entries with rob_idx 3 and 5, mispredict with flush_mask=8'h20 -> rob 5 is never issued, rob 3 still issues. Dispatch in the same cycle is ignored.
- lsu_busy=1 for 3 cycles with a ready entry -> no strobe. Issue occurs one cycle after lsu_busy drops. Assert rst_n mid-issue -> outputs 0 immediately.

Source files
------------

// File: rtl/lsu_issue_queue_pkg.sv
// Shared types for the LSU issue queue: entry layout, FU codes, funct3 encodings.
// Entry tag/ROB widths are fixed here and must match the TAG_W/ROB_W used by the top.
package lsu_pkg;

  localparam int LSIQ_TAG_W = 7;
  localparam int LSIQ_ROB_W = 3;

  localparam logic [2:0] FU_LD = 3'd6;
  localparam logic [2:0] FU_ST = 3'd7;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef struct packed {
    logic                  valid;
    logic                  is_st;
    logic [LSIQ_ROB_W-1:0] rob_idx;
    logic [2:0]            lsq_idx;
    logic [2:0]            f3;
    logic [31:0]           imm;
    logic [LSIQ_TAG_W-1:0] rs1_tag;
    logic                  rs1_rdy;
    logic [31:0]           rs1_data;
    logic [LSIQ_TAG_W-1:0] rs2_tag;
    logic                  rs2_rdy;
    logic [31:0]           rs2_data;
  } lsiq_entry_t;

  function automatic logic is_mem_op(input logic [2:0] fu_sel);
    return (fu_sel == FU_LD) || (fu_sel == FU_ST);
  endfunction

  // Returns {hit, data}; port 0 wins when both broadcast ports match the tag.
  function automatic logic [32:0] cdb_lookup(input logic [LSIQ_TAG_W-1:0]       tag,
                                             input logic [1:0]                  vld,
                                             input logic [1:0][LSIQ_TAG_W-1:0]  tags,
                                             input logic [1:0][31:0]            data);
    if (vld[0] && (tags[0] == tag)) return {1'b1, data[0]};
    if (vld[1] && (tags[1] == tag)) return {1'b1, data[1]};
    return '0;
  endfunction

endpackage

// File: rtl/lsu_issue_queue_if.sv
// Dispatch, result-broadcast, flush and LSU-issue signals of the LSU issue queue.
interface lsu_issue_queue_if #(
  parameter int TAG_W = 7,
  parameter int ROB_W = 3
);
  logic                    decode_valid;
  logic [2:0]              DC_fu_sel;
  logic [ROB_W-1:0]        DC_rob_idx;
  logic [2:0]              DC_lsq_idx;
  logic [2:0]              DC_funct3;
  logic [31:0]             DC_imm;
  logic [TAG_W-1:0]        DC_rs1_tag;
  logic [TAG_W-1:0]        DC_rs2_tag;
  logic                    DC_rs1_rdy;
  logic                    DC_rs2_rdy;
  logic [31:0]             DC_rs1_data;
  logic [31:0]             DC_rs2_data;
  logic                    iq_ready;
  logic [1:0]              cdb_valid;
  logic [1:0][TAG_W-1:0]   cdb_tag;
  logic [1:0][31:0]        cdb_data;
  logic                    lsu_busy;
  logic                    ld_i_valid;
  logic                    st_i_valid;
  logic [31:0]             lsu_i_rs1_data;
  logic [31:0]             lsu_i_rs2_data;
  logic [31:0]             lsu_i_imm;
  logic [2:0]              funct3;
  logic [ROB_W-1:0]        lsu_i_rob_idx;
  logic [2:0]              EX_ld_idx;
  logic [2:0]              EX_st_idx;
  logic                    mispredict;
  logic [(2**ROB_W)-1:0]   flush_mask;

  modport master (
    output decode_valid, DC_fu_sel, DC_rob_idx, DC_lsq_idx, DC_funct3, DC_imm,
           DC_rs1_tag, DC_rs2_tag, DC_rs1_rdy, DC_rs2_rdy, DC_rs1_data, DC_rs2_data,
           cdb_valid, cdb_tag, cdb_data, lsu_busy, mispredict, flush_mask,
    input  iq_ready, ld_i_valid, st_i_valid, lsu_i_rs1_data, lsu_i_rs2_data,
           lsu_i_imm, funct3, lsu_i_rob_idx, EX_ld_idx, EX_st_idx
  );

  modport slave (
    input  decode_valid, DC_fu_sel, DC_rob_idx, DC_lsq_idx, DC_funct3, DC_imm,
           DC_rs1_tag, DC_rs2_tag, DC_rs1_rdy, DC_rs2_rdy, DC_rs1_data, DC_rs2_data,
           cdb_valid, cdb_tag, cdb_data, lsu_busy, mispredict, flush_mask,
    output iq_ready, ld_i_valid, st_i_valid, lsu_i_rs1_data, lsu_i_rs2_data,
           lsu_i_imm, funct3, lsu_i_rob_idx, EX_ld_idx, EX_st_idx
  );
endinterface

// File: rtl/lsiq_age_select.sv
// Age matrix and oldest-eligible picker for the LSU issue queue.
module lsiq_age_select #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DEPTH-1:0]           valid,
  input  logic [DEPTH-1:0]           alloc_oh,
  input  logic [DEPTH-1:0]           free_oh,
  input  logic [DEPTH-1:0]           eligible,
  output logic [DEPTH-1:0]           sel_oh,
  output logic [$clog2(DEPTH)-1:0]   sel_idx,
  output logic                       sel_valid
);
  localparam int IDX_W = $clog2(DEPTH);

  // older[i][j] means entry j was dispatched before entry i.
  logic [DEPTH-1:0] older [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) older[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (alloc_oh[i])     older[i][j] <= valid[j] && !free_oh[j] && (i != j);
          else if (free_oh[j]) older[i][j] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    sel_oh    = '0;
    sel_idx   = '0;
    sel_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (eligible[i] && ((older[i] & eligible) == '0)) begin
        sel_oh[i] = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/lsu_issue_queue.sv
// Memory reservation station feeding the LSU: operand capture, oldest-ready issue, ROB-mask flush.
// Optional LSIQ_DISPATCH_BYPASS_EN: capture same-cycle broadcasts for operands at dispatch.
module lsu_issue_queue
  import lsu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = LSIQ_TAG_W,
  parameter int ROB_W = LSIQ_ROB_W
) (
  input  logic              clk,
  input  logic              rst_n,
  lsu_issue_queue_if.slave  io
);
  localparam int IDX_W = $clog2(DEPTH);

  lsiq_entry_t q      [DEPTH];
  lsiq_entry_t q_next [DEPTH];
  lsiq_entry_t new_entry;

  logic [DEPTH-1:0]       valid_vec, eligible, alloc_oh, free_oh, flush_vec, sel_oh;
  logic [IDX_W-1:0]       sel_idx;
  logic                   sel_valid, issue_fire, dispatch_ok, found;
  logic [1:0][TAG_W-1:0]  cdb_tag_in;
  logic [32:0]            wake1 [DEPTH];
  logic [32:0]            wake2 [DEPTH];

  assign cdb_tag_in  = io.cdb_tag;
  assign io.iq_ready = ~&valid_vec;
  assign dispatch_ok = io.decode_valid && is_mem_op(io.DC_fu_sel) && io.iq_ready && !io.mispredict;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i] = q[i].valid;
      eligible[i]  = q[i].valid && q[i].rs1_rdy && (q[i].rs2_rdy || !q[i].is_st) && !io.lsu_busy;
      flush_vec[i] = io.mispredict && q[i].valid && io.flush_mask[q[i].rob_idx];
      wake1[i]     = cdb_lookup(q[i].rs1_tag, io.cdb_valid, cdb_tag_in, io.cdb_data);
      wake2[i]     = cdb_lookup(q[i].rs2_tag, io.cdb_valid, cdb_tag_in, io.cdb_data);
    end
  end

  always_comb begin
    alloc_oh = '0;
    found    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid_vec[i] && !found) begin
        alloc_oh[i] = dispatch_ok;
        found       = 1'b1;
      end
    end
  end

  lsiq_age_select #(.DEPTH(DEPTH)) u_age (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid     (valid_vec),
    .alloc_oh  (alloc_oh),
    .free_oh   (free_oh),
    .eligible  (eligible),
    .sel_oh    (sel_oh),
    .sel_idx   (sel_idx),
    .sel_valid (sel_valid)
  );

  // An op flushed in the cycle it is selected must not produce a strobe.
  assign issue_fire = sel_valid && !flush_vec[sel_idx];
  assign free_oh    = flush_vec | (issue_fire ? sel_oh : '0);

`ifdef LSIQ_DISPATCH_BYPASS_EN
  logic [32:0] byp1, byp2;
`endif

  always_comb begin
    new_entry          = '0;
    new_entry.valid    = 1'b1;
    new_entry.is_st    = (io.DC_fu_sel == FU_ST);
    new_entry.rob_idx  = io.DC_rob_idx;
    new_entry.lsq_idx  = io.DC_lsq_idx;
    new_entry.f3       = io.DC_funct3;
    new_entry.imm      = io.DC_imm;
    new_entry.rs1_tag  = io.DC_rs1_tag;
    new_entry.rs1_rdy  = io.DC_rs1_rdy;
    new_entry.rs1_data = io.DC_rs1_data;
    new_entry.rs2_tag  = io.DC_rs2_tag;
    new_entry.rs2_rdy  = io.DC_rs2_rdy || (io.DC_fu_sel != FU_ST);
    new_entry.rs2_data = io.DC_rs2_data;
`ifdef LSIQ_DISPATCH_BYPASS_EN
    byp1 = cdb_lookup(io.DC_rs1_tag, io.cdb_valid, cdb_tag_in, io.cdb_data);
    byp2 = cdb_lookup(io.DC_rs2_tag, io.cdb_valid, cdb_tag_in, io.cdb_data);
    if (!new_entry.rs1_rdy && byp1[32]) begin
      new_entry.rs1_rdy  = 1'b1;
      new_entry.rs1_data = byp1[31:0];
    end
    if (!new_entry.rs2_rdy && byp2[32]) begin
      new_entry.rs2_rdy  = 1'b1;
      new_entry.rs2_data = byp2[31:0];
    end
`endif
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      q_next[i] = q[i];
      if (free_oh[i]) begin
        q_next[i].valid = 1'b0;
      end else if (q[i].valid) begin
        if (!q[i].rs1_rdy && wake1[i][32]) begin
          q_next[i].rs1_rdy  = 1'b1;
          q_next[i].rs1_data = wake1[i][31:0];
        end
        if (!q[i].rs2_rdy && wake2[i][32]) begin
          q_next[i].rs2_rdy  = 1'b1;
          q_next[i].rs2_data = wake2[i][31:0];
        end
      end
      if (alloc_oh[i]) q_next[i] = new_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else begin
      q <= q_next;
    end
  end

  // Issue register: strobes last one cycle, payload holds between issues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io.ld_i_valid     <= 1'b0;
      io.st_i_valid     <= 1'b0;
      io.lsu_i_rs1_data <= '0;
      io.lsu_i_rs2_data <= '0;
      io.lsu_i_imm      <= '0;
      io.funct3         <= '0;
      io.lsu_i_rob_idx  <= '0;
      io.EX_ld_idx      <= '0;
      io.EX_st_idx      <= '0;
    end else begin
      io.ld_i_valid <= issue_fire && !q[sel_idx].is_st;
      io.st_i_valid <= issue_fire &&  q[sel_idx].is_st;
      if (issue_fire) begin
        io.lsu_i_rs1_data <= q[sel_idx].rs1_data;
        io.lsu_i_rs2_data <= q[sel_idx].rs2_data;
        io.lsu_i_imm      <= q[sel_idx].imm;
        io.funct3         <= q[sel_idx].f3;
        io.lsu_i_rob_idx  <= ROB_W'(q[sel_idx].rob_idx);
        if (q[sel_idx].is_st) io.EX_st_idx <= q[sel_idx].lsq_idx;
        else                  io.EX_ld_idx <= q[sel_idx].lsq_idx;
      end
    end
  end
endmodule

// File: tb/tb_lsu_issue_queue.sv
// Directed scoreboard bench for lsu_issue_queue: expected issues are queued at dispatch, popped on strobes.
module tb_lsu_issue_queue;
  import lsu_pkg::*;

  localparam int DEPTH = 4;
  localparam int TAG_W = 7;
  localparam int ROB_W = 3;

  typedef struct {
    logic             is_st;
    logic [31:0]      rs1;
    logic [31:0]      rs2;
    logic [31:0]      imm;
    logic [2:0]       f3;
    logic [ROB_W-1:0] rob;
    logic [2:0]       lsq;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  exp_t exp_q [$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  lsu_issue_queue_if #(.TAG_W(TAG_W), .ROB_W(ROB_W)) bus ();

  lsu_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .ROB_W(ROB_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic is_st, input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [31:0] imm, input logic [2:0] f3,
                          input logic [ROB_W-1:0] rob, input logic [2:0] lsq);
    exp_t e;
    e.is_st = is_st; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm;
    e.f3 = f3; e.rob = rob; e.lsq = lsq;
    exp_q.push_back(e);
  endtask

  // Drives one dispatch for a single cycle; called at a negedge, returns at the next one.
  task automatic apply_stimulus(input logic is_st, input logic [ROB_W-1:0] rob, input logic [2:0] lsq,
                                input logic [2:0] f3, input logic [31:0] imm,
                                input logic [TAG_W-1:0] t1, input logic r1, input logic [31:0] d1,
                                input logic [TAG_W-1:0] t2, input logic r2, input logic [31:0] d2);
    bus.decode_valid = 1'b1;
    bus.DC_fu_sel    = is_st ? FU_ST : FU_LD;
    bus.DC_rob_idx   = rob;
    bus.DC_lsq_idx   = lsq;
    bus.DC_funct3    = f3;
    bus.DC_imm       = imm;
    bus.DC_rs1_tag   = t1;
    bus.DC_rs1_rdy   = r1;
    bus.DC_rs1_data  = d1;
    bus.DC_rs2_tag   = t2;
    bus.DC_rs2_rdy   = r2;
    bus.DC_rs2_data  = d2;
    @(negedge clk);
    bus.decode_valid = 1'b0;
  endtask

  task automatic broadcast(input logic [1:0] v, input logic [TAG_W-1:0] t0, input logic [31:0] d0,
                           input logic [TAG_W-1:0] t1, input logic [31:0] d1);
    bus.cdb_valid   = v;
    bus.cdb_tag[0]  = t0;
    bus.cdb_data[0] = d0;
    bus.cdb_tag[1]  = t1;
    bus.cdb_data[1] = d1;
    @(negedge clk);
    bus.cdb_valid = 2'b00;
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(negedge clk);
    check_output("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  // Every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && (bus.ld_i_valid || bus.st_i_valid)) begin
      check_output("issue_expected", 32'(exp_q.size() != 0), 32'd1);
      check_output("strobe_exclusive", 32'(bus.ld_i_valid && bus.st_i_valid), 32'd0);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check_output("issue_is_st", 32'(bus.st_i_valid), 32'(e.is_st));
        check_output("issue_rob", 32'(bus.lsu_i_rob_idx), 32'(e.rob));
        check_output("issue_rs1", bus.lsu_i_rs1_data, e.rs1);
        check_output("issue_imm", bus.lsu_i_imm, e.imm);
        check_output("issue_f3", 32'(bus.funct3), 32'(e.f3));
        if (e.is_st) begin
          check_output("issue_rs2", bus.lsu_i_rs2_data, e.rs2);
          check_output("issue_sq_idx", 32'(bus.EX_st_idx), 32'(e.lsq));
        end else begin
          check_output("issue_lq_idx", 32'(bus.EX_ld_idx), 32'(e.lsq));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.decode_valid = 1'b0;
    bus.DC_fu_sel    = 3'd0;
    bus.DC_rob_idx   = '0;
    bus.DC_lsq_idx   = '0;
    bus.DC_funct3    = '0;
    bus.DC_imm       = '0;
    bus.DC_rs1_tag   = '0;
    bus.DC_rs2_tag   = '0;
    bus.DC_rs1_rdy   = 1'b0;
    bus.DC_rs2_rdy   = 1'b0;
    bus.DC_rs1_data  = '0;
    bus.DC_rs2_data  = '0;
    bus.cdb_valid    = 2'b00;
    bus.cdb_tag      = '0;
    bus.cdb_data     = '0;
    bus.lsu_busy     = 1'b0;
    bus.mispredict   = 1'b0;
    bus.flush_mask   = '0;

    #12;
    check_output("rst_ld_valid", 32'(bus.ld_i_valid), 32'd0);
    check_output("rst_st_valid", 32'(bus.st_i_valid), 32'd0);
    check_output("rst_iq_ready", 32'(bus.iq_ready), 32'd1);
    check_output("rst_rs1_data", bus.lsu_i_rs1_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] load with ready operand");
    push_exp(1'b0, 32'h100, 32'h0, 32'h4, F3_LW, 3'd1, 3'd2);
    apply_stimulus(1'b0, 3'd1, 3'd2, F3_LW, 32'h4, 7'h01, 1'b1, 32'h100, 7'h00, 1'b0, 32'h0);
    check_output("t1_no_early_strobe", 32'(bus.ld_i_valid), 32'd0);
    @(negedge clk);
    check_output("t1_strobe_latency", 32'(bus.ld_i_valid), 32'd1);
    @(negedge clk);

    $display("[TB] store waiting on rs2");
    push_exp(1'b1, 32'h200, 32'hDEADBEEF, 32'h8, F3_SW, 3'd2, 3'd1);
    apply_stimulus(1'b1, 3'd2, 3'd1, F3_SW, 32'h8, 7'h02, 1'b1, 32'h200, 7'h15, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_output("t2_wait_no_strobe", 32'(bus.st_i_valid), 32'd0);
    end
    broadcast(2'b10, 7'h00, 32'h0, 7'h15, 32'hDEADBEEF);
    check_output("t2_select_cycle", 32'(bus.st_i_valid), 32'd0);
    @(negedge clk);
    check_output("t2_store_strobe", 32'(bus.st_i_valid), 32'd1);
    @(negedge clk);

    $display("[TB] fill queue and age ordering");
    for (int i = 0; i < 4; i++)
      apply_stimulus(1'b0, 3'(i), 3'(i), F3_LW, 32'(i * 4), 7'(8'h20 + i), 1'b0, 32'h0,
                     7'h00, 1'b0, 32'h0);
    check_output("t3_full_not_ready", 32'(bus.iq_ready), 32'd0);
    apply_stimulus(1'b0, 3'd6, 3'd6, F3_LW, 32'h60, 7'h00, 1'b1, 32'h6666, 7'h00, 1'b0, 32'h0);
    check_output("t3_still_full", 32'(bus.iq_ready), 32'd0);
    push_exp(1'b0, 32'h1021, 32'h0, 32'h4, F3_LW, 3'd1, 3'd1);
    broadcast(2'b01, 7'h21, 32'h1021, 7'h00, 32'h0);
    check_output("t3_full_during_select", 32'(bus.iq_ready), 32'd0);
    @(negedge clk);
    check_output("t3_slot_freed", 32'(bus.iq_ready), 32'd1);
    apply_stimulus(1'b0, 3'd4, 3'd4, F3_LW, 32'h10, 7'h24, 1'b0, 32'h0, 7'h00, 1'b0, 32'h0);
    push_exp(1'b0, 32'h1020, 32'h0, 32'h0, F3_LW, 3'd0, 3'd0);
    push_exp(1'b0, 32'h1022, 32'h0, 32'h8, F3_LW, 3'd2, 3'd2);
    push_exp(1'b0, 32'h1023, 32'h0, 32'hC, F3_LW, 3'd3, 3'd3);
    push_exp(1'b0, 32'h1024, 32'h0, 32'h10, F3_LW, 3'd4, 3'd4);
    broadcast(2'b11, 7'h20, 32'h1020, 7'h22, 32'h1022);
    broadcast(2'b11, 7'h23, 32'h1023, 7'h24, 32'h1024);
    drain();
    repeat (3) @(negedge clk);

    $display("[TB] younger ready load bypasses older store");
    push_exp(1'b0, 32'h400, 32'h0, 32'h10, F3_LBU, 3'd3, 3'd5);
    push_exp(1'b1, 32'h300, 32'hA0A0A0A0, 32'h20, F3_SB, 3'd2, 3'd3);
    apply_stimulus(1'b1, 3'd2, 3'd3, F3_SB, 32'h20, 7'h03, 1'b1, 32'h300, 7'h30, 1'b0, 32'h0);
    apply_stimulus(1'b0, 3'd3, 3'd5, F3_LBU, 32'h10, 7'h04, 1'b1, 32'h400, 7'h00, 1'b0, 32'h0);
    @(negedge clk);
    broadcast(2'b11, 7'h30, 32'hA0A0A0A0, 7'h30, 32'hB0B0B0B0);
    drain();
    repeat (3) @(negedge clk);

    $display("[TB] mispredict flush by ROB mask");
    push_exp(1'b0, 32'h3333, 32'h0, 32'h30, F3_LH, 3'd3, 3'd6);
    apply_stimulus(1'b0, 3'd3, 3'd6, F3_LH, 32'h30, 7'h40, 1'b0, 32'h0, 7'h00, 1'b0, 32'h0);
    apply_stimulus(1'b0, 3'd5, 3'd7, F3_LH, 32'h50, 7'h41, 1'b0, 32'h0, 7'h00, 1'b0, 32'h0);
    bus.mispredict = 1'b1;
    bus.flush_mask = 8'h20;
    apply_stimulus(1'b0, 3'd7, 3'd0, F3_LW, 32'h70, 7'h00, 1'b1, 32'h7777, 7'h00, 1'b0, 32'h0);
    bus.mispredict = 1'b0;
    bus.flush_mask = 8'h00;
    broadcast(2'b11, 7'h40, 32'h3333, 7'h41, 32'h5555);
    drain();
    repeat (3) @(negedge clk);
    apply_stimulus(1'b0, 3'd6, 3'd1, F3_LW, 32'h64, 7'h00, 1'b1, 32'h6060, 7'h00, 1'b0, 32'h0);
    bus.mispredict = 1'b1;
    bus.flush_mask = 8'h40;
    @(negedge clk);
    bus.mispredict = 1'b0;
    bus.flush_mask = 8'h00;
    check_output("t5_flushed_select_no_strobe", 32'(bus.ld_i_valid), 32'd0);
    check_output("t5_empty_after_flush", 32'(bus.iq_ready), 32'd1);
    repeat (2) @(negedge clk);

    $display("[TB] lsu_busy stall and async reset");
    bus.lsu_busy = 1'b1;
    push_exp(1'b0, 32'h777, 32'h0, 32'h44, F3_LW, 3'd1, 3'd2);
    apply_stimulus(1'b0, 3'd1, 3'd2, F3_LW, 32'h44, 7'h00, 1'b1, 32'h777, 7'h00, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_output("t6_busy_no_strobe", 32'(bus.ld_i_valid), 32'd0);
    end
    bus.lsu_busy = 1'b0;
    @(negedge clk);
    check_output("t6_issue_after_busy", 32'(bus.ld_i_valid), 32'd1);
    @(negedge clk);
    push_exp(1'b0, 32'h999, 32'h0, 32'h48, F3_LW, 3'd2, 3'd3);
    apply_stimulus(1'b0, 3'd2, 3'd3, F3_LW, 32'h48, 7'h00, 1'b1, 32'h999, 7'h00, 1'b0, 32'h0);
    @(negedge clk);
    check_output("t6_strobe_before_reset", 32'(bus.ld_i_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("t6_rst_ld_valid", 32'(bus.ld_i_valid), 32'd0);
    check_output("t6_rst_rs1_data", bus.lsu_i_rs1_data, 32'd0);
    check_output("t6_rst_imm", bus.lsu_i_imm, 32'd0);
    check_output("t6_rst_ld_idx", 32'(bus.EX_ld_idx), 32'd0);
    check_output("t6_rst_iq_ready", 32'(bus.iq_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    check_output("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
